// File: rtl/uart_cmd_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl_pkg
//   Shared definitions for the UART command controller: default frame start
//   byte, parser and handshake state encodings, and the frame checksum helper.
// ----------------------------------------------------------------------------
package uart_cmd_ctrl_pkg;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // Parser position inside a SYNC, ADDR, DHI, DLO, CSUM frame
   typedef enum logic [2:0] {
      S_SYNC,
      S_ADDR,
      S_DHI,
      S_DLO,
      S_CSUM
   } parse_state_e;

   // Receiver handshake: waiting for rx_rdy, or holding rx_clr until it drops
   typedef enum logic {
      H_WAIT,
      H_CLR
   } hs_state_e;

   // Expected CSUM byte of a frame
   function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                             input logic [7:0] dhi,
                                             input logic [7:0] dlo);
      return addr ^ dhi ^ dlo;
   endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl_if
//   Byte handshake between the UART receiver and its consumer.
//   rx_data : received byte, valid while rx_rdy = 1
//   rx_rdy  : byte-ready flag raised by the receiver
//   rx_clr  : clear request returned by the consumer
//   master = receiver side, slave = consumer side.
// ----------------------------------------------------------------------------
interface uart_cmd_ctrl_if;

   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       rx_clr;

   modport master (output rx_data, output rx_rdy, input rx_clr);
   modport slave  (input rx_data, input rx_rdy, output rx_clr);

endinterface

// File: rtl/uart_rx_hs.sv
// ----------------------------------------------------------------------------
// uart_rx_hs
//   Runs the rdy/clr handshake of the UART receiver and latches each byte.
//   Usable by any consumer of the receiver, not only the command parser.
//   clk, rst   : clock, synchronous active-high reset
//   rx_data_i  : byte from the receiver
//   rx_rdy_i   : byte-ready flag from the receiver
//   rx_clr_o   : clear request, high from acceptance until rx_rdy is seen low
//   byte_vld_o : one-cycle pulse, byte_o holds a fresh byte
//   byte_o     : last accepted byte
// ----------------------------------------------------------------------------
module uart_rx_hs
   import uart_cmd_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data_i,
   input  logic       rx_rdy_i,
   output logic       rx_clr_o,
   output logic       byte_vld_o,
   output logic [7:0] byte_o
);

   hs_state_e  state_q, state_d;
   logic       rx_clr_q, rx_clr_d;
   logic       vld_q, vld_d;
   logic [7:0] byte_q, byte_d;

   always_comb begin
      // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
      state_d  = state_q;
      rx_clr_d = rx_clr_q;
      vld_d    = 1'b0;
      byte_d   = byte_q;
      unique case (state_q)
         H_WAIT: begin
            // A byte still pending when reset releases is taken here as new.
            if (rx_rdy_i) begin
               byte_d   = rx_data_i;
               vld_d    = 1'b1;
               rx_clr_d = 1'b1;
               state_d  = H_CLR;
            end
         end
         H_CLR: begin
            if (!rx_rdy_i) begin
               rx_clr_d = 1'b0;
               state_d  = H_WAIT;
            end
         end
         default: state_d = H_WAIT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= H_WAIT;
         rx_clr_q <= 1'b0;
         vld_q    <= 1'b0;
         byte_q   <= '0;
      end else begin
         state_q  <= state_d;
         rx_clr_q <= rx_clr_d;
         vld_q    <= vld_d;
         byte_q   <= byte_d;
      end
   end

   assign rx_clr_o   = rx_clr_q;
   assign byte_vld_o = vld_q;
   assign byte_o     = byte_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// uart_cmd_ctrl
//   Assembles 5-byte command frames (SYNC, ADDR, DHI, DLO, CSUM) from the UART
//   receiver, checks them and issues one register-write strobe per good frame.
//   clk, rst    : clock, synchronous active-high reset
//   rx_if       : receiver handshake (slave side)
//   reg_addr_o  : write address, held until the next write
//   reg_wdata_o : write data {DHI, DLO}, held until the next write
//   reg_we_o    : one-cycle write strobe
//   frame_err_o : one-cycle pulse on checksum, address or timeout error
//   err_cnt_o   : saturating frame error count
//   busy_o      : parser is inside a frame
// ----------------------------------------------------------------------------
module uart_cmd_ctrl
   import uart_cmd_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned TIMEOUT  = 1024,
   parameter logic [7:0]  SYNC     = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   uart_cmd_ctrl_if.slave    rx_if,
   output logic [ADDR_W-1:0] reg_addr_o,
   output logic [15:0]       reg_wdata_o,
   output logic              reg_we_o,
   output logic              frame_err_o,
   output logic [7:0]        err_cnt_o,
   output logic              busy_o
);

   localparam int unsigned      TMO_W    = $clog2(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   logic       byte_vld;
   logic [7:0] rx_byte;

   uart_rx_hs u_rx_hs (
      .clk        (clk),
      .rst        (rst),
      .rx_data_i  (rx_if.rx_data),
      .rx_rdy_i   (rx_if.rx_rdy),
      .rx_clr_o   (rx_if.rx_clr),
      .byte_vld_o (byte_vld),
      .byte_o     (rx_byte)
   );

   parse_state_e      state_q, state_d;
   logic [7:0]        addr_q, addr_d;
   logic [7:0]        dhi_q, dhi_d;
   logic [7:0]        dlo_q, dlo_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [15:0]       reg_wdata_q, reg_wdata_d;
   logic              reg_we_q, reg_we_d;
   logic              frame_err_q, frame_err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic              frame_ok;
   logic              err_hit;

   // The whole ADDR byte is range-checked, not just the ADDR_W bits written out.
   assign frame_ok = (rx_byte == frame_csum(addr_q, dhi_q, dlo_q)) &&
                     (32'(addr_q) < NUM_REGS);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      dhi_d       = dhi_q;
      dlo_d       = dlo_q;
      tmo_d       = tmo_q + 1'b1;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      frame_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      err_hit     = 1'b0;

      // A byte arriving in the same cycle as the timeout takes priority.
      if (byte_vld) begin
         tmo_d = '0;
         unique case (state_q)
            S_SYNC: if (rx_byte == SYNC) state_d = S_ADDR;
            S_ADDR: begin addr_d = rx_byte; state_d = S_DHI;  end
            S_DHI:  begin dhi_d  = rx_byte; state_d = S_DLO;  end
            S_DLO:  begin dlo_d  = rx_byte; state_d = S_CSUM; end
            S_CSUM: begin
               state_d = S_SYNC;
               if (frame_ok) begin
                  reg_addr_d  = addr_q[ADDR_W-1:0];
                  reg_wdata_d = {dhi_q, dlo_q};
                  reg_we_d    = 1'b1;
               end else begin
                  err_hit = 1'b1;
               end
            end
            default: state_d = S_SYNC;
         endcase
      end else if (state_q == S_SYNC) begin
         tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
         state_d = S_SYNC;
         tmo_d   = '0;
         err_hit = 1'b1;
      end

      if (err_hit) begin
         frame_err_d = 1'b1;
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_SYNC;
         addr_q      <= '0;
         dhi_q       <= '0;
         dlo_q       <= '0;
         tmo_q       <= '0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         frame_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         dhi_q       <= dhi_d;
         dlo_q       <= dlo_d;
         tmo_q       <= tmo_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign reg_addr_o  = reg_addr_q;
   assign reg_wdata_o = reg_wdata_q;
   assign reg_we_o    = reg_we_q;
   assign frame_err_o = frame_err_q;
   assign err_cnt_o   = err_cnt_q;
   assign busy_o      = (state_q != S_SYNC);

endmodule
